// File: rtl/subtractor_serial.sv
// Digit-serial subtractor: difference = a - b - borrow_in, digit_width bits per clock, LSB digit first.
// Define SUBTRACTOR_OVERFLOW_EN to add the registered two's-complement overflow output.

module subtractor_digit #(
   parameter int width = 2
) (
   input  logic [width-1:0] a,
   input  logic [width-1:0] b,
   input  logic             borrow_in,
   output logic [width-1:0] d,
   output logic             borrow_out
);
   logic [width:0] full;

   // The extra top bit of the widened difference is the outgoing borrow.
   assign full       = {1'b0, a} - {1'b0, b} - {{width{1'b0}}, borrow_in};
   assign d          = full[width-1:0];
   assign borrow_out = full[width];
endmodule

module subtractor_serial #(
   parameter int bit_width   = 8,
   parameter int digit_width = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [bit_width-1:0] a,
   input  logic [bit_width-1:0] b,
   input  logic                 borrow_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [bit_width-1:0] difference,
`ifdef SUBTRACTOR_OVERFLOW_EN
   output logic                 overflow,
`endif
   output logic                 borrow_out
);
   localparam int STEPS = bit_width / digit_width;
   localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [SW-1:0] LAST = SW'(STEPS - 1);

   generate
      if (digit_width < 1 || (bit_width % digit_width) != 0) begin : g_bad_cfg
         $error("subtractor_serial: digit_width must divide bit_width");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                 state;
   logic [bit_width-1:0]   a_sr, b_sr, res_sr, res_next;
   logic                   borrow;
   logic [SW-1:0]          step;
   logic [digit_width-1:0] d;
   logic                   borrow_nx;
`ifdef SUBTRACTOR_OVERFLOW_EN
   logic                   sign_a, sign_b;
`endif

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   subtractor_digit #(.width(digit_width)) u_digit (
      .a          (a_sr[digit_width-1:0]),
      .b          (b_sr[digit_width-1:0]),
      .borrow_in  (borrow),
      .d          (d),
      .borrow_out (borrow_nx)
   );

   // Result digits enter at the MSB end so the LSB digit lands at bit 0 after STEPS shifts.
   generate
      if (STEPS == 1) begin : g_single
         assign res_next = d;
      end else begin : g_multi
         assign res_next = {d, res_sr[bit_width-1:digit_width]};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         a_sr       <= '0;
         b_sr       <= '0;
         res_sr     <= '0;
         borrow     <= 1'b0;
         step       <= '0;
         difference <= '0;
         borrow_out <= 1'b0;
`ifdef SUBTRACTOR_OVERFLOW_EN
         sign_a     <= 1'b0;
         sign_b     <= 1'b0;
         overflow   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sr   <= a;
                  b_sr   <= b;
                  borrow <= borrow_in;
                  step   <= '0;
`ifdef SUBTRACTOR_OVERFLOW_EN
                  sign_a <= a[bit_width-1];
                  sign_b <= b[bit_width-1];
`endif
                  state  <= RUN;
               end
            end
            RUN: begin
               a_sr   <= a_sr >> digit_width;
               b_sr   <= b_sr >> digit_width;
               res_sr <= res_next;
               borrow <= borrow_nx;
               step   <= step + 1'b1;
               if (step == LAST) begin
                  difference <= res_next;
                  borrow_out <= borrow_nx;
`ifdef SUBTRACTOR_OVERFLOW_EN
                  overflow   <= (sign_a != sign_b) && (res_next[bit_width-1] != sign_a);
`endif
                  state      <= DONE;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_subtractor_serial.sv
// Directed bench for subtractor_serial at defaults (8-bit, 2-bit digits, 4 compute cycles).
// Overflow checks are compiled in when SUBTRACTOR_OVERFLOW_EN is defined.

module tb_subtractor_serial;
   logic       clk, rst_n;
   logic       in_valid, in_ready, out_valid, out_ready;
   logic [7:0] a, b, difference;
   logic       borrow_in, borrow_out;
`ifdef SUBTRACTOR_OVERFLOW_EN
   logic       overflow;
`endif

   int nvec = 0;
   int nmis = 0;
   int cyc_cnt = 0;
   int acc_q[$];
   logic [7:0] res_q[$];

   subtractor_serial #(.bit_width(8), .digit_width(2)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
      .borrow_in  (borrow_in),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .difference (difference),
`ifdef SUBTRACTOR_OVERFLOW_EN
      .overflow   (overflow),
`endif
      .borrow_out (borrow_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Records handshake cycles and accepted results for the back-to-back check.
   always @(posedge clk) begin
      if (in_valid && in_ready) acc_q.push_back(cyc_cnt);
      if (out_valid && out_ready) res_q.push_back(difference);
      cyc_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nmis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic start_op(input logic [7:0] ia, input logic [7:0] ib, input logic ibin);
      chk("in_ready_idle", 32'(in_ready), 32'd1);
      a = ia; b = ib; borrow_in = ibin; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; a = ~ia; b = ~ib; borrow_in = ~ibin;
      chk("in_ready_busy", 32'(in_ready), 32'd0);
   endtask

   task automatic wait_done(input string tag, input logic [7:0] ed, input logic eb, input logic eov);
      int cyc = 0;
      while (!out_valid && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk({tag, "_latency"}, 32'(cyc), 32'd4);
      chk({tag, "_diff"}, 32'(difference), 32'(ed));
      chk({tag, "_borrow"}, 32'(borrow_out), 32'(eb));
`ifdef SUBTRACTOR_OVERFLOW_EN
      chk({tag, "_ovf"}, 32'(overflow), 32'(eov));
`endif
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("release_in_ready", 32'(in_ready), 32'd1);
      chk("release_out_valid", 32'(out_valid), 32'd0);
   endtask

   task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                         input logic [7:0] ed, input logic eb, input logic eov);
      start_op(ia, ib, ibin);
      wait_done(tag, ed, eb, eov);
      release_result();
   endtask

   initial begin
      int t;
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; borrow_in = 1'b0;
      #1 rst_n = 1'b0;
      #10;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_diff", 32'(difference), 32'd0);
      chk("rst_borrow", 32'(borrow_out), 32'd0);
      #11 rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic op followed by backpressure with noisy inputs.
      start_op(8'h35, 8'h12, 1'b0);
      wait_done("op35_12", 8'h23, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         a = 8'($urandom); b = 8'($urandom); in_valid = ~in_valid; borrow_in = ~borrow_in;
         @(posedge clk); #1;
         chk("bp_diff", 32'(difference), 32'h23);
         chk("bp_borrow", 32'(borrow_out), 32'd0);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      release_result();

      run_op("op00_01",   8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
      run_op("op10_0F_1", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
      run_op("op00_00_1", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
      run_op("opFF_FF",   8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);
      run_op("op80_01",   8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
      run_op("op05_03",   8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
      run_op("op7F_FF",   8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);

      // Back-to-back with in_valid held high and out_ready held high.
      acc_q.delete(); res_q.delete();
      a = 8'h35; b = 8'h12; borrow_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      a = 8'hFF; b = 8'h0F;
      t = 0;
      while (acc_q.size() < 2 && t < 30) begin @(posedge clk); #1; t++; end
      in_valid = 1'b0;
      chk("b2b_accepts", 32'(acc_q.size()), 32'd2);
      if (acc_q.size() == 2) chk("b2b_spacing", 32'(acc_q[1] - acc_q[0]), 32'd6);
      t = 0;
      while (res_q.size() < 2 && t < 30) begin @(posedge clk); #1; t++; end
      out_ready = 1'b0;
      chk("b2b_results", 32'(res_q.size()), 32'd2);
      if (res_q.size() == 2) begin
         chk("b2b_res0", 32'(res_q[0]), 32'h23);
         chk("b2b_res1", 32'(res_q[1]), 32'hF0);
      end

      // Reset two steps into a run; outputs must clear without a clock edge.
      start_op(8'h5A, 8'h3C, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_diff", 32'(difference), 32'd0);
      chk("midrst_borrow", 32'(borrow_out), 32'd0);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      run_op("post_rst", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule
